// File: rtl/mdu_sched.sv
// Multiply/divide scheduler for the E stage: owns HI/LO, models fixed
// multi-cycle latency with a down-counter, and raises the D-stage stall.
//
// state   | meaning
// IDLE    | no operation in flight; new MD ops may be accepted
// MUL_RUN | MULT/MULTU result pending, counting down MULT_CYCLES
// DIV_RUN | DIV/DIVU result pending, counting down DIV_CYCLES
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StartE,
  input  logic [2:0]  MDUOpE,
  input  logic [31:0] RsE,
  input  logic [31:0] RtE,
  input  logic        ReqE,
  input  logic        ReadSelE,
  input  logic        MDInD,
  output logic [31:0] MDOutE,
  output logic        Busy,
  output logic        StallD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

  localparam logic [7:0] MUL_CNT = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_CNT = 8'(DIV_CYCLES);

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_nowr;

  logic        is_mul, is_div, is_md, acc;
  logic        sgn;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, uq, ur, quo, rem;

  assign is_mul = (MDUOpE == 3'd1) || (MDUOpE == 3'd2);
  assign is_div = (MDUOpE == 3'd3) || (MDUOpE == 3'd4);
  assign is_md  = is_mul || is_div;
  assign acc    = StartE && !ReqE && (state == IDLE) &&
                  (MDUOpE >= 3'd1) && (MDUOpE <= 3'd6);

  // Low 64 bits of the product of sign/zero-extended operands give both
  // the signed and unsigned result from one multiplier.
  assign sgn  = (MDUOpE == 3'd1) || (MDUOpE == 3'd3);
  assign prod = {{32{sgn & RsE[31]}}, RsE} * {{32{sgn & RtE[31]}}, RtE};

  always_comb begin
    mag_a = (sgn && RsE[31]) ? -RsE : RsE;
    mag_b = (sgn && RtE[31]) ? -RtE : RtE;
    if (RtE == 32'd0) mag_b = 32'd1;
    uq  = mag_a / mag_b;
    ur  = mag_a % mag_b;
    quo = (sgn && (RsE[31] ^ RtE[31])) ? -uq : uq;
    rem = (sgn && RsE[31]) ? -ur : ur;
    // Overflow case pinned down rather than left to the divider.
    if (sgn && (RsE == 32'h8000_0000) && (RtE == 32'hFFFF_FFFF)) begin
      quo = 32'h8000_0000;
      rem = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (acc && is_mul)      state_nx = MUL_RUN;
        else if (acc && is_div) state_nx = DIV_RUN;
      end
      MUL_RUN, DIV_RUN: begin
        if (cnt == 8'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy   = (state != IDLE);
    StallD = MDInD && (Busy || (acc && is_md));
    MDOutE = ReadSelE ? HI : LO;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 8'd0;
      HI        <= 32'd0;
      LO        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_nowr <= 1'b0;
    end else if (acc) begin
      case (MDUOpE)
        3'd1, 3'd2: begin
          pend_hi   <= prod[63:32];
          pend_lo   <= prod[31:0];
          pend_nowr <= 1'b0;
          cnt       <= MUL_CNT;
        end
        3'd3, 3'd4: begin
          pend_hi   <= rem;
          pend_lo   <= quo;
          pend_nowr <= (RtE == 32'd0);
          cnt       <= DIV_CNT;
        end
        3'd5:    HI <= RsE;
        3'd6:    LO <= RsE;
        default: ;
      endcase
    end else if (state != IDLE) begin
      if (cnt == 8'd1) begin
        if (!pend_nowr) begin
          HI <= pend_hi;
          LO <= pend_lo;
        end
        cnt <= 8'd0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Bench for mdu_sched: directed cases plus random ops, checked by a
// scoreboard that pops expected HI/LO whenever Busy falls.
module tb_mdu_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n, StartE, ReqE, ReadSelE, MDInD;
  logic [2:0]  MDUOpE;
  logic [31:0] RsE, RtE;
  logic [31:0] MDOutE, HI, LO;
  logic        Busy, StallD;

  always #5 clk = ~clk;

  mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .StartE(StartE), .MDUOpE(MDUOpE),
    .RsE(RsE), .RtE(RtE), .ReqE(ReqE), .ReadSelE(ReadSelE), .MDInD(MDInD),
    .MDOutE(MDOutE), .Busy(Busy), .StallD(StallD), .HI(HI), .LO(LO)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          force_md = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference: plain ISA arithmetic on 64-bit integers.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output bit wr);
    longint sa, sb, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    h  = 32'd0;
    l  = 32'd0;
    case (op)
      3'd1: begin q = sa * sb; h = q[63:32]; l = q[31:0]; end
      3'd2: begin up = 64'(a) * 64'(b); h = up[63:32]; l = up[31:0]; end
      3'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      3'd4: begin
        if (b == 32'd0) wr = 1'b0;
        else begin l = a / b; h = a % b; end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    ReadSelE = 1'($urandom_range(0, 1));
    MDInD    = force_md ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Monitor: cycle-level busy/stall expectations and scoreboard pops.
  initial begin
    int  busy_left;
    int  len;
    bit  bprev;
    bit  exp_acc, exp_stall;
    exp_t e;
    busy_left = 0; len = 0; bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_left = 0; len = 0; bprev = 1'b0;
      end else begin
        exp_acc   = StartE && !ReqE && (busy_left == 0) && (MDUOpE inside {[3'd1:3'd6]});
        exp_stall = MDInD && ((busy_left > 0) || (exp_acc && (MDUOpE inside {[3'd1:3'd4]})));
        chk("busy", 32'(Busy), 32'(busy_left > 0));
        chk("stall", 32'(StallD), 32'(exp_stall));
        if (Busy) len++;
        if (bprev && !Busy) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: completion with empty queue, got busy fall required none");
          end else begin
            e = sbq.pop_front();
            chk("sb_hi", HI, e.hi);
            chk("sb_lo", LO, e.lo);
            chk("sb_mdout", MDOutE, ReadSelE ? e.hi : e.lo);
            chk("sb_busy_len", 32'(len), 32'(e.len));
          end
          len = 0;
        end
        bprev = Busy;
        if (exp_acc && (MDUOpE inside {3'd1, 3'd2}))      busy_left = MC;
        else if (exp_acc && (MDUOpE inside {3'd3, 3'd4})) busy_left = DC;
        else if (busy_left > 0)                           busy_left--;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (Busy === 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle", 32'(Busy), 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    exp_t e;
    logic [31:0] h, l;
    bit wr, acc;
    wait_idle();
    StartE = 1'b1; MDUOpE = op; RsE = a; RtE = b; ReqE = req;
    acc = !req && (op >= 3'd1) && (op <= 3'd6);
    if (acc && op <= 3'd4) begin
      model(op, a, b, h, l, wr);
      if (wr) begin m_hi = h; m_lo = l; end
      e.hi = m_hi; e.lo = m_lo;
      e.len = (op <= 3'd2) ? MC : DC;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    StartE = 1'b0; ReqE = 1'b0; MDUOpE = 3'd0;
    if (acc && op == 3'd5) m_hi = a;
    if (acc && op == 3'd6) m_lo = a;
    if (!(acc && op <= 3'd4)) begin
      chk("direct_hi", HI, m_hi);
      chk("direct_lo", LO, m_lo);
      chk("direct_busy", 32'(Busy), 32'd0);
    end
  endtask

  task automatic ghost();
    StartE = 1'b1; MDUOpE = 3'($urandom_range(1, 6)); RsE = $urandom; RtE = $urandom; ReqE = 1'b0;
    @(posedge clk); #1;
    StartE = 1'b0; MDUOpE = 3'd0;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation time limit reached, got hang required finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        req;
    int          sel;
    reset_n = 1'b0; StartE = 1'b0; ReqE = 1'b0; MDUOpE = 3'd0;
    RsE = 32'd0; RtE = 32'd0; ReadSelE = 1'b0; MDInD = 1'b0;
    #12;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_stall", 32'(StallD), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle();
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle();
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();
    chk("div_hi", HI, 32'hFFFF_FFFF);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle();
    chk("divu_hi", HI, 32'h0000_0001);
    chk("divu_lo", LO, 32'h7FFF_FFFC);

    issue(3'd5, 32'h1234, 32'd0, 1'b0);
    issue(3'd6, 32'h5678, 32'd0, 1'b0);
    issue(3'd3, 32'd55, 32'd0, 1'b0);
    wait_idle();
    chk("div0_hi", HI, 32'h1234);
    chk("div0_lo", LO, 32'h5678);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    chk("ovf_hi", HI, 32'd0);
    chk("ovf_lo", LO, 32'h8000_0000);

    force_md = 1'b1;
    issue(3'd1, 32'd7, 32'd9, 1'b0);
    ghost();
    wait_idle();
    force_md = 1'b0;
    chk("midrun_hi", HI, 32'd0);
    chk("midrun_lo", LO, 32'd63);

    issue(3'd1, 32'd2, 32'd3, 1'b1);
    issue(3'd6, 32'hABCD, 32'd0, 1'b0);
    chk("mtlo_lo", LO, 32'hABCD);

    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin op = 3'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 100); b = $urandom_range(1, 10); end
      req = ($urandom_range(0, 5) == 0);
      issue(op, a, b, req);
      if (!req && op >= 3'd1 && op <= 3'd4 && $urandom_range(0, 2) == 0) ghost();
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end

    issue(3'd5, 32'hDEAD, 32'd0, 1'b0);
    issue(3'd3, 32'd1000, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    sbq.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);
    chk("post_rst_busy", 32'(Busy), 32'd0);

    issue(3'd2, 32'h0001_0000, 32'h0001_0000, 1'b0);
    wait_idle();
    @(negedge clk); @(negedge clk);
    chk("final_hi", HI, 32'd1);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
